// File: rtl/nn_pkg.sv
// Shared fixed-point types and scheduler state encoding for the neuron layer blocks.
// Words are signed Q5.10: 16 bits total, 10 fractional bits, 0x0400 = 1.0.
// No logic here; types and constants only.
package nn_pkg;

  localparam int PRECISION = 16;
  localparam int FRAC_BITS = 10;

  typedef logic signed [PRECISION-1:0] fixed_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    WAIT,
    EMIT
  } sched_state_e;

endpackage

// File: rtl/neuron_layer_sched.sv
// Purpose : time-multiplexes one shared N-input neuron datapath across the M neurons of a layer.
// Latency : first result DP_LATENCY+3 cycles after input accept, then DP_LATENCY+4 per neuron.
// Backpr. : out_ready=0 holds EMIT with every output stable; in_ready is high only in IDLE.
// Ports   : in_valid/in_ready/x_in  - input vector handshake
//           wb_addr -> wb_weights/wb_bias - synchronous weight ROM (data one cycle after address)
//           dp_x/dp_weights/dp_bias -> dp_result - shared datapath operands and result
//           out_valid/out_ready/out_data/out_idx/out_last - per-neuron result stream
module neuron_layer_sched #(
  parameter int N          = 4,
  parameter int PRECISION  = 16,
  parameter int M          = 8,
  parameter int DP_LATENCY = 1,
  parameter int RELU       = 0,
  localparam int AW        = (M > 1) ? $clog2(M) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N-1:0][PRECISION-1:0] x_in,
  output logic [AW-1:0]               wb_addr,
  input  logic [N-1:0][PRECISION-1:0] wb_weights,
  input  logic [PRECISION-1:0]        wb_bias,
  output logic [N-1:0][PRECISION-1:0] dp_x,
  output logic [N-1:0][PRECISION-1:0] dp_weights,
  output logic [PRECISION-1:0]        dp_bias,
  input  logic [PRECISION-1:0]        dp_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PRECISION-1:0]        out_data,
  output logic [AW-1:0]               out_idx,
  output logic                        out_last
);
  import nn_pkg::*;

  localparam int          CW       = (DP_LATENCY > 0) ? $clog2(DP_LATENCY + 1) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(M - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(DP_LATENCY);

  sched_state_e                r_state;
  sched_state_e                w_state_nxt;
  logic [AW-1:0]               r_idx;
  logic [CW-1:0]               r_cnt;
  logic [N-1:0][PRECISION-1:0] r_x;
  logic [N-1:0][PRECISION-1:0] r_w;
  logic [PRECISION-1:0]        r_b;
  logic [PRECISION-1:0]        r_data;
  logic [AW-1:0]               r_out_idx;
  logic                        r_last;

  logic                        w_accept;
  logic                        w_out_hs;
  logic                        w_is_last;
  logic                        w_wait_done;
  logic [PRECISION-1:0]        w_result;

  assign w_accept    = (r_state == IDLE) && in_valid;
  assign w_out_hs    = (r_state == EMIT) && out_ready;
  assign w_is_last   = (r_idx == LAST_IDX);
  assign w_wait_done = (r_cnt == '0);

  // ReLU only zeroes negative results; saturation belongs to the datapath.
  always_comb begin
    w_result = dp_result;
    if (RELU != 0 && dp_result[PRECISION-1]) begin
      w_result = '0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = FETCH;
      FETCH:   w_state_nxt = LOAD;
      LOAD:    w_state_nxt = WAIT;
      WAIT:    if (w_wait_done) w_state_nxt = EMIT;
      EMIT:    if (out_ready) w_state_nxt = w_is_last ? IDLE : FETCH;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == EMIT);
  end

  // Datapath registers: latched input, neuron index, operands, WAIT counter, result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_cnt     <= '0;
      r_x       <= '0;
      r_w       <= '0;
      r_b       <= '0;
      r_data    <= '0;
      r_out_idx <= '0;
      r_last    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x   <= x_in;
        r_idx <= '0;
      end else if (w_out_hs && !w_is_last) begin
        r_idx <= r_idx + AW'(1);
      end

      // ROM data for r_idx is valid in LOAD because the address was presented during FETCH.
      if (r_state == LOAD) begin
        r_w   <= wb_weights;
        r_b   <= wb_bias;
        r_cnt <= CNT_INIT;
      end else if (r_state == WAIT && !w_wait_done) begin
        r_cnt <= r_cnt - CW'(1);
      end

      if (r_state == WAIT && w_wait_done) begin
        r_data    <= w_result;
        r_out_idx <= r_idx;
        r_last    <= w_is_last;
      end
    end
  end

  // The ROM address is the neuron index itself, so it holds through backpressure.
  assign wb_addr    = r_idx;
  assign dp_x       = r_x;
  assign dp_weights = r_w;
  assign dp_bias    = r_b;
  assign out_data   = r_data;
  assign out_idx    = r_out_idx;
  assign out_last   = r_last;

endmodule

// File: tb/tb_neuron_layer_sched.sv
// Directed bench for neuron_layer_sched with behavioural ROM and datapath models.
// Instance a: M=2 DP_LATENCY=1 RELU=0; b: M=2 DP_LATENCY=0 RELU=1; c: M=1 DP_LATENCY=1.
// Expected values are hand-computed Q5.10 constants.
module tb_neuron_layer_sched;

  logic clk;
  logic rst_n;
  logic [3:0][15:0] x_in;

  logic in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a;
  logic in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b;
  logic in_valid_c, in_ready_c, out_valid_c, out_ready_c, out_last_c;
  logic [0:0] wb_addr_a, wb_addr_b, wb_addr_c;
  logic [0:0] out_idx_a, out_idx_b, out_idx_c;
  logic [3:0][15:0] wb_w_a, wb_w_b, wb_w_c;
  logic [15:0]      wb_b_a, wb_b_b, wb_b_c;
  logic [3:0][15:0] dp_x_a, dp_x_b, dp_x_c, dp_w_a, dp_w_b, dp_w_c;
  logic [15:0]      dp_b_a, dp_b_b, dp_b_c, dp_res_a, dp_res_b, dp_res_c;
  logic [15:0]      out_data_a, out_data_b, out_data_c;

  logic [3:0][15:0] rom_w [0:1];
  logic [15:0]      rom_b [0:1];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Q5.10 dot product plus bias, each product rescaled by 2^-10.
  function automatic logic [15:0] dp_fn(input logic [3:0][15:0] x, input logic [3:0][15:0] w,
                                        input logic [15:0] b);
    logic signed [31:0] acc;
    logic signed [31:0] p;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      p   = $signed(x[i]) * $signed(w[i]);
      acc = acc + (p >>> 10);
    end
    return acc[15:0] + b;
  endfunction

  // Synchronous ROMs: data one cycle after address.
  always @(posedge clk) begin
    wb_w_a <= rom_w[wb_addr_a]; wb_b_a <= rom_b[wb_addr_a];
    wb_w_b <= rom_w[wb_addr_b]; wb_b_b <= rom_b[wb_addr_b];
    wb_w_c <= rom_w[wb_addr_c]; wb_b_c <= rom_b[wb_addr_c];
  end

  // Datapaths: one register stage for a and c, combinational for b.
  always @(posedge clk) begin
    dp_res_a <= dp_fn(dp_x_a, dp_w_a, dp_b_a);
    dp_res_c <= dp_fn(dp_x_c, dp_w_c, dp_b_c);
  end
  assign dp_res_b = dp_fn(dp_x_b, dp_w_b, dp_b_b);

  neuron_layer_sched #(.N(4), .PRECISION(16), .M(2), .DP_LATENCY(1), .RELU(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a), .x_in(x_in),
    .wb_addr(wb_addr_a), .wb_weights(wb_w_a), .wb_bias(wb_b_a),
    .dp_x(dp_x_a), .dp_weights(dp_w_a), .dp_bias(dp_b_a), .dp_result(dp_res_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_idx(out_idx_a), .out_last(out_last_a));

  neuron_layer_sched #(.N(4), .PRECISION(16), .M(2), .DP_LATENCY(0), .RELU(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .x_in(x_in),
    .wb_addr(wb_addr_b), .wb_weights(wb_w_b), .wb_bias(wb_b_b),
    .dp_x(dp_x_b), .dp_weights(dp_w_b), .dp_bias(dp_b_b), .dp_result(dp_res_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_idx(out_idx_b), .out_last(out_last_b));

  neuron_layer_sched #(.N(4), .PRECISION(16), .M(1), .DP_LATENCY(1), .RELU(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c), .x_in(x_in),
    .wb_addr(wb_addr_c), .wb_weights(wb_w_c), .wb_bias(wb_b_c),
    .dp_x(dp_x_c), .dp_weights(dp_w_c), .dp_bias(dp_b_c), .dp_result(dp_res_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .out_data(out_data_c),
    .out_idx(out_idx_c), .out_last(out_last_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic vld(input int sel);
    case (sel)
      0:       return out_valid_a;
      1:       return out_valid_b;
      default: return out_valid_c;
    endcase
  endfunction

  // Count cycles from the current edge until out_valid, bounded at 20.
  task automatic wait_out(input int sel, input int exp_cyc, input string tag);
    int c;
    c = 0;
    while (!vld(sel) && c < 20) begin
      tick();
      c++;
    end
    chk(tag, c, exp_cyc);
  endtask

  localparam logic [15:0] ONE = 16'h0400;
  localparam logic [15:0] TWO = 16'h0800;
  localparam logic [15:0] NEG = 16'hFC00;

  initial begin
    rom_w[0] = {ONE, TWO, ONE, ONE}; rom_b[0] = 16'h0001;
    rom_w[1] = {NEG, NEG, NEG, NEG}; rom_b[1] = 16'h0000;
    rst_n = 1'b0;
    x_in  = {ONE, ONE, ONE, TWO};
    in_valid_a = 0; out_ready_a = 0;
    in_valid_b = 0; out_ready_b = 0;
    in_valid_c = 0; out_ready_c = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_data", out_data_a, 0);
    chk("rst_wb_addr", wb_addr_a, 0);
    chk("rst_dp_bias", dp_b_a, 0);
    chk("rst_out_last", out_last_a, 0);

    // Layer pass 1 on a, with backpressure on neuron 0 and busy input change
    in_valid_a = 1;
    tick();
    in_valid_a = 0;
    chk("a_busy_in_ready", in_ready_a, 0);
    wait_out(0, 4, "a_lat_first");
    chk("a_n0_data", out_data_a, 16'h1801);
    chk("a_n0_idx", out_idx_a, 0);
    chk("a_n0_last", out_last_a, 0);
    x_in = {TWO, TWO, TWO, TWO};
    in_valid_a = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", out_valid_a, 1);
      chk("bp_data", out_data_a, 16'h1801);
      chk("bp_idx", out_idx_a, 0);
      chk("bp_wb_addr", wb_addr_a, 0);
      chk("bp_in_ready", in_ready_a, 0);
    end
    out_ready_a = 1;
    tick();
    wait_out(0, 4, "a_lat_next");
    chk("a_n1_data", out_data_a, 16'hEC00);
    chk("a_n1_idx", out_idx_a, 1);
    chk("a_n1_last", out_last_a, 1);
    chk("a_n1_wb_addr", wb_addr_a, 1);

    // Back-to-back: in_valid still high, new vector {2,2,2,2}
    tick();
    chk("b2b_in_ready", in_ready_a, 1);
    chk("b2b_out_valid", out_valid_a, 0);
    tick();
    in_valid_a = 0;
    wait_out(0, 4, "b2b_lat");
    chk("b2b_n0_data", out_data_a, 16'h2801);
    chk("b2b_n0_idx", out_idx_a, 0);
    tick();
    wait_out(0, 4, "b2b_lat_next");
    chk("b2b_n1_data", out_data_a, 16'hE000);
    chk("b2b_n1_last", out_last_a, 1);
    tick();

    // Reset asserted during EMIT
    x_in = {ONE, ONE, ONE, TWO};
    out_ready_a = 0;
    in_valid_a  = 1;
    tick();
    in_valid_a = 0;
    wait_out(0, 4, "pre_rst_lat");
    chk("pre_rst_data", out_data_a, 16'h1801);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid_a, 0);
    chk("mid_rst_out_data", out_data_a, 0);
    chk("mid_rst_dp_bias", dp_b_a, 0);
    chk("mid_rst_dp_x", dp_x_a, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready_a, 1);
    chk("post_rst_out_valid", out_valid_a, 0);

    // Instance b: combinational datapath, ReLU enabled
    in_valid_b  = 1;
    out_ready_b = 1;
    tick();
    in_valid_b = 0;
    wait_out(1, 3, "b_lat_first");
    chk("b_n0_data", out_data_b, 16'h1801);
    chk("b_n0_idx", out_idx_b, 0);
    chk("b_n0_last", out_last_b, 0);
    tick();
    wait_out(1, 3, "b_lat_next");
    chk("b_n1_relu_data", out_data_b, 16'h0000);
    chk("b_n1_idx", out_idx_b, 1);
    chk("b_n1_last", out_last_b, 1);
    tick();
    chk("b_done_in_ready", in_ready_b, 1);

    // Instance c: single neuron layer
    in_valid_c  = 1;
    out_ready_c = 1;
    tick();
    in_valid_c = 0;
    wait_out(2, 4, "c_lat");
    chk("c_data", out_data_c, 16'h1801);
    chk("c_idx", out_idx_c, 0);
    chk("c_last", out_last_c, 1);
    tick();
    chk("c_done_in_ready", in_ready_c, 1);
    chk("c_done_out_valid", out_valid_c, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
